// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: host-side write strobe, data and status bundle for uart_tx_fifo.
interface uart_tx_fifo_if #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16
);
   logic                        start;
   logic [DATA_BITS-1:0]        data;
   logic                        busy;
   logic                        full;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic                        overflow;
   logic                        tx_done;
   logic                        UART_Tx;
   modport master (output start, data, input busy, full, fifo_count, overflow, tx_done, UART_Tx);
   modport slave  (input start, data, output busy, full, fifo_count, overflow, tx_done, UART_Tx);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter fed by a transmit FIFO.
// Queued words go out back-to-back; UART_Tx is driven straight from a flop.
module uart_tx_fifo #(
   parameter int CLK_HZ     = 100_000_000,
   parameter int BAUD       = 10_000,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input logic           Clk_100M,
   input logic           Reset,
   uart_tx_fifo_if.slave bus
);
   localparam int DIV = CLK_HZ / BAUD;
   localparam int CW  = $clog2(DIV);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int NW  = AW + 1;
   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
   state_t               state, state_n;
   logic [CW-1:0]        cnt;
   logic [3:0]           idx;
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [DATA_BITS-1:0] shreg;
   logic                 par;
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [NW-1:0]        count_n;
   logic                 tick, wr, pop, tx_n, done_n;

   always_comb begin
      tick    = cnt == CW'(DIV - 1);
      wr      = bus.start && !bus.full;
      state_n = state;
      pop     = 1'b0;
      tx_n    = bus.UART_Tx;
      done_n  = 1'b0;
      case (state)
         IDLE:  if (bus.fifo_count != '0) begin state_n = START; pop = 1'b1; tx_n = 1'b0; end
         START: if (tick) begin state_n = DATA; tx_n = shreg[0]; end
         DATA:  if (tick) begin
            if (idx != 4'(DATA_BITS - 1)) tx_n = shreg[1];
            else if (PARITY != 0) begin state_n = PAR; tx_n = par; end
            else begin state_n = STOP; tx_n = 1'b1; end
         end
         PAR:   if (tick) begin state_n = STOP; tx_n = 1'b1; end
         STOP:  if (tick && idx == 4'(STOP_BITS - 1)) begin
            done_n  = 1'b1;
            pop     = bus.fifo_count != '0;
            state_n = pop ? START : IDLE;
            tx_n    = !pop;
         end
         default: state_n = IDLE;
      endcase
      count_n = bus.fifo_count + NW'(wr) - NW'(pop);
   end

   always_ff @(posedge Clk_100M or posedge Reset)
      if (Reset) begin
         state          <= IDLE;
         cnt            <= '0;
         idx            <= '0;
         shreg          <= '0;
         par            <= 1'b0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         bus.fifo_count <= '0;
         bus.full       <= 1'b0;
         bus.busy       <= 1'b0;
         bus.overflow   <= 1'b0;
         bus.tx_done    <= 1'b0;
         bus.UART_Tx    <= 1'b1;
      end else begin
         state <= state_n;
         cnt   <= (state == IDLE || tick) ? '0 : cnt + CW'(1);
         idx   <= (state_n != state) ? '0 : idx + 4'(tick);
         // parity is latched from the popped word so later writes cannot disturb the frame
         if (pop) begin
            shreg <= mem[rd_ptr];
            par   <= ^mem[rd_ptr] ^ (PARITY == 1);
         end else if (state == DATA && tick) shreg <= shreg >> 1;
         rd_ptr         <= rd_ptr + AW'(pop);
         wr_ptr         <= wr_ptr + AW'(wr);
         bus.fifo_count <= count_n;
         bus.full       <= count_n == NW'(FIFO_DEPTH);
         bus.busy       <= state_n != IDLE || count_n != '0;
         bus.overflow   <= bus.overflow | (bus.start & bus.full);
         bus.tx_done    <= done_n;
         bus.UART_Tx    <= tx_n;
      end

   always_ff @(posedge Clk_100M)
      if (wr) mem[wr_ptr] <= bus.data;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: four configurations (8N1, 8E1, 8O1, 7E2; DIV=10, depth 4) driven in
// lockstep and compared each cycle against a queue-plus-frame-countdown reference model.
module tb_uart_tx_fifo;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_s = 1'b0;
   logic [8:0] din = '0;
   int         n_chk = 0, n_pass = 0;
   int         nb[4] = '{8, 8, 8, 7};
   int         pm[4] = '{0, 2, 1, 2};
   int         sb[4] = '{1, 1, 1, 2};
   logic [8:0] q[4][$];
   logic [8:0] cur[4];
   int         r[4];
   bit         ovf[4], done[4];
   logic [7:0] st[4];
   int         lat, pulses;

   always #5 clk = ~clk;

   uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) m0(), m1(), m2();
   uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) m3();

   uart_tx_fifo #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
      u0 (.Clk_100M(clk), .Reset(rst), .bus(m0));
   uart_tx_fifo #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
      u1 (.Clk_100M(clk), .Reset(rst), .bus(m1));
   uart_tx_fifo #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
      u2 (.Clk_100M(clk), .Reset(rst), .bus(m2));
   uart_tx_fifo #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4))
      u3 (.Clk_100M(clk), .Reset(rst), .bus(m3));

   assign m0.start = start_s;
   assign m1.start = start_s;
   assign m2.start = start_s;
   assign m3.start = start_s;
   assign m0.data  = din[7:0];
   assign m1.data  = din[7:0];
   assign m2.data  = din[7:0];
   assign m3.data  = din[6:0];
   assign st[0] = {m0.fifo_count, m0.full, m0.busy, m0.overflow, m0.tx_done, m0.UART_Tx};
   assign st[1] = {m1.fifo_count, m1.full, m1.busy, m1.overflow, m1.tx_done, m1.UART_Tx};
   assign st[2] = {m2.fifo_count, m2.full, m2.busy, m2.overflow, m2.tx_done, m2.UART_Tx};
   assign st[3] = {m3.fifo_count, m3.full, m3.busy, m3.overflow, m3.tx_done, m3.UART_Tx};

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   function automatic int flen(input int i);
      return 10 * (1 + nb[i] + (pm[i] != 0 ? 1 : 0) + sb[i]);
   endfunction

   // bit k of the frame for word w: start, data LSB first, optional parity, stop bits
   function automatic logic fbit(input logic [8:0] w, input int k, input int i);
      int ones = 0;
      if (k == 0) return 1'b0;
      if (k <= nb[i]) return w[k-1];
      if (pm[i] != 0 && k == nb[i] + 1) begin
         for (int j = 0; j < nb[i]; j++) ones += int'(w[j]);
         return pm[i] == 1 ? (ones % 2 == 0) : (ones % 2 == 1);
      end
      return 1'b1;
   endfunction

   task automatic cyc();
      bit pf, pop;
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         if (rst) begin
            q[i].delete();
            r[i] = 0;
            ovf[i] = 0;
            done[i] = 0;
         end else begin
            pf = q[i].size() == 4;
            if (start_s && pf) ovf[i] = 1;
            pop = q[i].size() > 0 && r[i] <= 1;
            done[i] = r[i] == 1;
            if (r[i] > 0) r[i]--;
            if (pop) begin
               cur[i] = q[i].pop_front();
               r[i] = flen(i);
            end
            if (start_s && !pf) q[i].push_back(din);
         end
      end
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("i%0d UART_Tx", i), int'(st[i][0]), r[i] == 0 ? 1 : int'(fbit(cur[i], (flen(i) - r[i]) / 10, i)));
         chk($sformatf("i%0d tx_done", i), int'(st[i][1]), int'(done[i]));
         chk($sformatf("i%0d overflow", i), int'(st[i][2]), int'(ovf[i]));
         chk($sformatf("i%0d busy", i), int'(st[i][3]), int'(r[i] > 0 || q[i].size() > 0));
         chk($sformatf("i%0d full", i), int'(st[i][4]), int'(q[i].size() == 4));
         chk($sformatf("i%0d fifo_count", i), int'(st[i][7:5]), q[i].size());
      end
   endtask

   task automatic put(input logic [8:0] w);
      start_s = 1'b1;
      din = w;
      cyc();
      start_s = 1'b0;
   endtask

   initial begin
      repeat (3) cyc();
      rst = 1'b0;
      put(9'h0A5);
      lat = 0;
      for (int n = 1; n <= 200; n++) begin
         cyc();
         if (n == 96) begin
            chk("8E1 parity A5", int'(m1.UART_Tx), 0);
            chk("8O1 parity A5", int'(m2.UART_Tx), 1);
         end
         if (m0.tx_done && lat == 0) lat = n;
      end
      chk("tx_done latency", lat, 101);
      put(9'h07F);
      for (int n = 1; n <= 200; n++) begin
         cyc();
         if (n == 86) chk("7E2 parity 7F", int'(m3.UART_Tx), 1);
      end
      pulses = 0;
      put(9'h000);
      put(9'h0FF);
      put(9'h055);
      for (int n = 0; n < 400; n++) begin
         cyc();
         pulses += int'(m0.tx_done);
      end
      chk("stream tx_done pulses", pulses, 3);
      put(9'h1C3);
      cyc();
      for (int j = 0; j < 6; j++) begin
         put(9'($urandom));
         if (j == 3) chk("full after 4th", int'(m0.full), 1);
         if (j == 4) chk("overflow after 5th", int'(m0.overflow), 1);
      end
      repeat (700) cyc();
      rst = 1'b1;
      repeat (2) cyc();
      rst = 1'b0;
      for (int j = 0; j < 5; j++) put(9'($urandom));
      for (int t = 0; t < 400 && !(r[0] == 1 && q[0].size() == 4); t++) cyc();
      chk("reach full pop edge", int'(r[0] == 1 && q[0].size() == 4), 1);
      put(9'h0E7);
      chk("simul full count", int'(m0.fifo_count), 3);
      chk("simul full overflow", int'(m0.overflow), 1);
      for (int t = 0; t < 400 && !(r[0] == 1 && q[0].size() == 2); t++) cyc();
      chk("reach count2 pop edge", int'(r[0] == 1 && q[0].size() == 2), 1);
      put(9'h018);
      chk("simul count2", int'(m0.fifo_count), 2);
      repeat (700) cyc();
      put(9'($urandom));
      repeat (46) cyc();
      #1 rst = 1'b1;
      #1;
      chk("async reset line", int'(m0.UART_Tx), 1);
      chk("async reset status", int'(st[0]), 8'h01);
      repeat (2) cyc();
      rst = 1'b0;
      put(9'h03C);
      repeat (200) cyc();
      for (int n = 0; n < 2000; n++) begin
         start_s = $urandom_range(0, 7) == 0;
         din = 9'($urandom);
         rst = $urandom_range(0, 999) == 0;
         cyc();
      end
      start_s = 1'b0;
      rst = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
